// File: rtl/dflow_replay_sequencer_if.sv
// Core-side control bus of the dflow replay sequencer: run requests and the
// memory window toward the generator core, plus the core's status flags.
interface dflow_replay_sequencer_if #(
  parameter int QDR_ADDR_WIDTH = 19
);
  logic                      init_calib_complete;
  logic                      compelete_store;
  logic                      compelete_replay;
  logic                      sw_rst;
  logic                      start_store;
  logic                      start_replay;
  logic [QDR_ADDR_WIDTH-1:0] mem_addr_low;
  logic [QDR_ADDR_WIDTH-1:0] mem_addr_high;

  modport master (
    input  init_calib_complete, compelete_store, compelete_replay,
    output sw_rst, start_store, start_replay, mem_addr_low, mem_addr_high
  );

  modport slave (
    output init_calib_complete, compelete_store, compelete_replay,
    input  sw_rst, start_store, start_replay, mem_addr_low, mem_addr_high
  );
endinterface

// File: rtl/dflow_replay_sequencer.sv
// Run-control FSM for the dflow generator core (qdr_clk domain).
// Sequence per job: wait calibration -> soft reset -> optional store ->
// replay passes separated by a programmable gap, with a per-phase watchdog
// and an abort path that always finishes with a soft-reset pulse.
// Every output is registered from the next-state decode, so a decision
// taken on the inputs of one cycle shows up on the outputs one cycle later.
module dflow_replay_sequencer #(
  parameter int QDR_ADDR_WIDTH = 19,
  parameter int LOOP_W         = 16,
  parameter int GAP_W          = 16,
  parameter int TIMEOUT_W      = 24,
  parameter int RST_CYCLES     = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cmd_start,
  input  logic                      cmd_abort,
  input  logic                      cfg_store_en,
  input  logic [QDR_ADDR_WIDTH-1:0] cfg_mem_addr_low,
  input  logic [QDR_ADDR_WIDTH-1:0] cfg_mem_addr_high,
  input  logic [LOOP_W-1:0]         cfg_loop_count,
  input  logic [GAP_W-1:0]          cfg_gap_cycles,
  dflow_replay_sequencer_if.master  core,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic [LOOP_W-1:0]         loops_done
);

  localparam int RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CALIB, S_RST, S_STORE, S_STORE_REL, S_GAP,
    S_REPLAY, S_REPLAY_REL, S_DONE, S_ERROR, S_ABORT
  } state_t;

  state_t             state, state_n;
  logic [RCW-1:0]     rst_cnt, rst_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [TIMEOUT_W-1:0] wd_cnt, wd_cnt_n;
  logic               err_pulse, err_pulse_n;
  logic               store_en_q;
  logic [LOOP_W-1:0]  loop_q;
  logic [GAP_W-1:0]   gap_q;
  logic               done_n, error_n;
  logic [1:0]         err_code_n;
  logic [LOOP_W-1:0]  loops_n;
  logic               accept;
  logic               idle_like;
  logic               rst_last;
  logic               wd_hit;
  logic               gap_over;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next-state decode plus the next values of counters and status flags.
  // The watchdog trips one count before all-ones so the phase lasts exactly
  // 2^TIMEOUT_W-1 cycles; the top two codes both count as expired so a
  // completion that lands on the last count still times out its *_REL wait.
  always_comb begin
    state_n     = state;
    rst_cnt_n   = rst_cnt;
    gap_cnt_n   = gap_cnt;
    wd_cnt_n    = '0;
    err_pulse_n = err_pulse;
    done_n      = done;
    error_n     = error;
    err_code_n  = err_code;
    loops_n     = loops_done;
    accept      = 1'b0;
    idle_like   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    rst_last    = (rst_cnt == RST_LAST);
    wd_hit      = &wd_cnt[TIMEOUT_W-1:1];
    gap_over    = ({1'b0, gap_cnt} + {{GAP_W{1'b0}}, 1'b1}) >= {1'b0, gap_q};

    if (cmd_abort && !idle_like && (state != S_ABORT)) begin
      state_n   = S_ABORT;
      rst_cnt_n = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if ((state == S_ERROR) && err_pulse) begin
            if (rst_last) err_pulse_n = 1'b0;
            else          rst_cnt_n   = rst_cnt + 1'b1;
          end
          if (cmd_start && !cmd_abort) begin
            accept      = 1'b1;
            done_n      = 1'b0;
            error_n     = 1'b0;
            err_code_n  = 2'd0;
            loops_n     = '0;
            err_pulse_n = 1'b0;
            rst_cnt_n   = '0;
            if (cfg_mem_addr_low > cfg_mem_addr_high) begin
              state_n    = S_ERROR;
              error_n    = 1'b1;
              err_code_n = 2'd1;
            end else begin
              state_n = S_CALIB;
            end
          end
        end
        S_CALIB: begin
          if (core.init_calib_complete) begin
            state_n   = S_RST;
            rst_cnt_n = '0;
          end
        end
        S_RST: begin
          if (rst_last) state_n   = store_en_q ? S_STORE : S_REPLAY;
          else          rst_cnt_n = rst_cnt + 1'b1;
        end
        S_STORE: begin
          wd_cnt_n = wd_cnt + 1'b1;
          if (core.compelete_store) begin
            state_n = S_STORE_REL;
          end else if (wd_hit) begin
            state_n     = S_ERROR;
            error_n     = 1'b1;
            err_code_n  = 2'd2;
            err_pulse_n = 1'b1;
            rst_cnt_n   = '0;
          end
        end
        S_STORE_REL: begin
          wd_cnt_n = wd_cnt + 1'b1;
          if (!core.compelete_store) begin
            state_n  = S_REPLAY;
            wd_cnt_n = '0;
          end else if (wd_hit) begin
            state_n     = S_ERROR;
            error_n     = 1'b1;
            err_code_n  = 2'd2;
            err_pulse_n = 1'b1;
            rst_cnt_n   = '0;
          end
        end
        S_REPLAY: begin
          wd_cnt_n = wd_cnt + 1'b1;
          if (core.compelete_replay) begin
            state_n = S_REPLAY_REL;
            loops_n = loops_done + 1'b1;
          end else if (wd_hit) begin
            state_n     = S_ERROR;
            error_n     = 1'b1;
            err_code_n  = 2'd3;
            err_pulse_n = 1'b1;
            rst_cnt_n   = '0;
          end
        end
        S_REPLAY_REL: begin
          wd_cnt_n = wd_cnt + 1'b1;
          if (!core.compelete_replay) begin
            if ((loop_q != '0) && (loops_done == loop_q)) begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end else begin
              state_n   = S_GAP;
              gap_cnt_n = '0;
            end
          end else if (wd_hit) begin
            state_n     = S_ERROR;
            error_n     = 1'b1;
            err_code_n  = 2'd3;
            err_pulse_n = 1'b1;
            rst_cnt_n   = '0;
          end
        end
        S_GAP: begin
          if (gap_over) state_n   = S_REPLAY;
          else          gap_cnt_n = gap_cnt + 1'b1;
        end
        S_ABORT: begin
          if (rst_last) state_n   = S_IDLE;
          else          rst_cnt_n = rst_cnt + 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Counters, latched job configuration and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_cnt            <= '0;
      gap_cnt            <= '0;
      wd_cnt             <= '0;
      err_pulse          <= 1'b0;
      store_en_q         <= 1'b0;
      loop_q             <= '0;
      gap_q              <= '0;
      core.sw_rst        <= 1'b0;
      core.start_store   <= 1'b0;
      core.start_replay  <= 1'b0;
      core.mem_addr_low  <= '0;
      core.mem_addr_high <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      err_code           <= 2'd0;
      loops_done         <= '0;
    end else begin
      rst_cnt           <= rst_cnt_n;
      gap_cnt           <= gap_cnt_n;
      wd_cnt            <= wd_cnt_n;
      err_pulse         <= err_pulse_n;
      core.sw_rst       <= (state_n == S_RST) || (state_n == S_ABORT) ||
                           ((state_n == S_ERROR) && err_pulse_n);
      core.start_store  <= (state_n == S_STORE);
      core.start_replay <= (state_n == S_REPLAY);
      busy              <= !((state_n == S_IDLE) || (state_n == S_DONE) ||
                             (state_n == S_ERROR));
      done              <= done_n;
      error             <= error_n;
      err_code          <= err_code_n;
      loops_done        <= loops_n;
      if (accept) begin
        store_en_q         <= cfg_store_en;
        loop_q             <= cfg_loop_count;
        gap_q              <= cfg_gap_cycles;
        core.mem_addr_low  <= cfg_mem_addr_low;
        core.mem_addr_high <= cfg_mem_addr_high;
      end
    end
  end

endmodule

// File: tb/tb_dflow_replay_sequencer.sv
// Scoreboard bench for dflow_replay_sequencer: the stimulus process queues
// the expected output events of each job, a monitor turns the DUT outputs
// into events (pulse lengths, replay gaps, job status) and compares them.
module tb_dflow_replay_sequencer;

  localparam int AW = 19;
  localparam int LW = 16;
  localparam int GW = 16;
  localparam int TW = 8;
  localparam int RC = 8;

  localparam int EV_SWRST  = 0;
  localparam int EV_STORE  = 1;
  localparam int EV_REPLAY = 2;
  localparam int EV_GAP    = 3;
  localparam int EV_STATUS = 4;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic          clk;
  logic          resetn;
  logic          cmd_start;
  logic          cmd_abort;
  logic          cfg_store_en;
  logic [AW-1:0] cfg_mem_addr_low;
  logic [AW-1:0] cfg_mem_addr_high;
  logic [LW-1:0] cfg_loop_count;
  logic [GW-1:0] cfg_gap_cycles;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [LW-1:0] loops_done;

  int  checks = 0;
  int  errors = 0;
  int  core_lat = 20;
  int  act_cycles = 0;
  ev_t sb_q[$];

  dflow_replay_sequencer_if #(.QDR_ADDR_WIDTH(AW)) core_bus ();

  dflow_replay_sequencer #(
    .QDR_ADDR_WIDTH(AW),
    .LOOP_W        (LW),
    .GAP_W         (GW),
    .TIMEOUT_W     (TW),
    .RST_CYCLES    (RC)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cmd_start        (cmd_start),
    .cmd_abort        (cmd_abort),
    .cfg_store_en     (cfg_store_en),
    .cfg_mem_addr_low (cfg_mem_addr_low),
    .cfg_mem_addr_high(cfg_mem_addr_high),
    .cfg_loop_count   (cfg_loop_count),
    .cfg_gap_cycles   (cfg_gap_cycles),
    .core             (core_bus),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .err_code         (err_code),
    .loops_done       (loops_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string ev_name(int k);
    case (k)
      EV_SWRST:  return "sw_rst_len";
      EV_STORE:  return "store_len";
      EV_REPLAY: return "replay_len";
      EV_GAP:    return "replay_gap";
      EV_STATUS: return "status";
      default:   return "unknown";
    endcase
  endfunction

  function automatic int status_val(int d, int e, int c, int l);
    return (d << 19) | (e << 18) | (c << 16) | l;
  endfunction

  task automatic expectEv(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got %s=%0d, expected no event", ev_name(kind), val);
    end else begin
      e = sb_q.pop_front();
      if ((e.kind != kind) || (e.val != val)) begin
        errors++;
        $display("[TB] FAIL event_%s: got %s=0x%0h, expected %s=0x%0h",
                 ev_name(e.kind), ev_name(kind), val, ev_name(e.kind), e.val);
      end
    end
  endtask

  task automatic applyStimulus(input bit store_en, input int lo, input int hi,
                               input int loops, input int gap);
    @(negedge clk);
    cfg_store_en      = store_en;
    cfg_mem_addr_low  = AW'(lo);
    cfg_mem_addr_high = AW'(hi);
    cfg_loop_count    = LW'(loops);
    cfg_gap_cycles    = GW'(gap);
    cmd_start         = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic drainScoreboard(input string name, input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got %0d events pending after %0d cycles, expected 0",
               name, sb_q.size(), budget);
      sb_q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic waitReplayPass(input int loops, input string name);
    int n;
    n = 0;
    while (!(core_bus.start_replay && (int'(loops_done) == loops)) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("[TB] FAIL %s_wait: got no replay with loops_done=%0d, expected one within 3000 cycles",
               name, loops);
    end
  endtask

  // Core emulation: raise the completion flag core_lat cycles after a request
  // rises (never when core_lat is 0) and drop it once the request is removed.
  initial begin : core_model
    int st_cnt;
    int rp_cnt;
    st_cnt = 0;
    rp_cnt = 0;
    core_bus.compelete_store  = 1'b0;
    core_bus.compelete_replay = 1'b0;
    forever begin
      @(negedge clk);
      if (core_bus.start_store) begin
        if (!core_bus.compelete_store) begin
          st_cnt++;
          if ((core_lat != 0) && (st_cnt == core_lat)) core_bus.compelete_store = 1'b1;
        end
      end else begin
        core_bus.compelete_store = 1'b0;
        st_cnt = 0;
      end
      if (core_bus.start_replay) begin
        if (!core_bus.compelete_replay) begin
          rp_cnt++;
          if ((core_lat != 0) && (rp_cnt == core_lat)) core_bus.compelete_replay = 1'b1;
        end
      end else begin
        core_bus.compelete_replay = 1'b0;
        rp_cnt = 0;
      end
    end
  end

  // Monitor: convert output waveforms into events and check the invariants.
  initial begin : monitor
    logic p_sw, p_ss, p_sr, p_busy, p_done, p_err;
    int   sw_len, ss_len, sr_len, low_len;
    bit   rp_seen;
    p_sw = 0; p_ss = 0; p_sr = 0; p_busy = 0; p_done = 0; p_err = 0;
    sw_len = 0; ss_len = 0; sr_len = 0; low_len = 0; rp_seen = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        p_sw = 0; p_ss = 0; p_sr = 0; p_busy = 0; p_done = 0; p_err = 0;
        sw_len = 0; ss_len = 0; sr_len = 0; low_len = 0; rp_seen = 0;
      end else begin
        checks++;
        if ((core_bus.start_store && core_bus.start_replay) ||
            ((core_bus.start_store || core_bus.start_replay) && core_bus.sw_rst)) begin
          errors++;
          $display("[TB] FAIL output_overlap: got sw_rst=%0b start_store=%0b start_replay=%0b, expected at most one high",
                   core_bus.sw_rst, core_bus.start_store, core_bus.start_replay);
        end
        if (core_bus.sw_rst || core_bus.start_store || core_bus.start_replay) act_cycles++;

        if (core_bus.sw_rst) sw_len++;
        else if (p_sw) begin
          observe(EV_SWRST, sw_len);
          sw_len = 0;
        end

        if (core_bus.start_store) ss_len++;
        else if (p_ss) begin
          observe(EV_STORE, ss_len);
          ss_len = 0;
        end

        if (core_bus.start_replay) begin
          if (!p_sr && rp_seen) observe(EV_GAP, low_len);
          sr_len++;
        end else begin
          if (p_sr) begin
            observe(EV_REPLAY, sr_len);
            sr_len  = 0;
            rp_seen = 1;
            low_len = 0;
          end
          low_len++;
        end

        if ((p_busy && !busy) || (done && !p_done) || (error && !p_err))
          observe(EV_STATUS, status_val(int'(done), int'(error), int'(err_code), int'(loops_done)));

        if (!busy) rp_seen = 0;
        p_sw   = core_bus.sw_rst;
        p_ss   = core_bus.start_store;
        p_sr   = core_bus.start_replay;
        p_busy = busy;
        p_done = done;
        p_err  = error;
      end
    end
  end

  // Hard stop in case something wedges the stimulus process.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no end of test, expected finish before 500000 ns");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    resetn = 1'b0;
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    cfg_store_en = 1'b0;
    cfg_mem_addr_low = '0;
    cfg_mem_addr_high = '0;
    cfg_loop_count = '0;
    cfg_gap_cycles = '0;
    core_bus.init_calib_complete = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                64'({core_bus.sw_rst, core_bus.start_store, core_bus.start_replay, busy, done,
                     error, err_code, loops_done, core_bus.mem_addr_low, core_bus.mem_addr_high}),
                64'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] job: store + 3 replays, gap 4");
    core_lat = 20;
    expectEv(EV_SWRST, 8);
    expectEv(EV_STORE, 20);
    expectEv(EV_REPLAY, 20);
    expectEv(EV_GAP, 5);
    expectEv(EV_REPLAY, 20);
    expectEv(EV_GAP, 5);
    expectEv(EV_REPLAY, 20);
    expectEv(EV_STATUS, status_val(1, 0, 0, 3));
    applyStimulus(1'b1, 'h10, 'h1F, 3, 4);
    drainScoreboard("normal_job", 400);
    checkOutput("normal_addr_low", 64'(core_bus.mem_addr_low), 64'('h10));
    checkOutput("normal_addr_high", 64'(core_bus.mem_addr_high), 64'('h1F));

    $display("[TB] job: low above high");
    expectEv(EV_STATUS, status_val(0, 1, 1, 0));
    applyStimulus(1'b1, 'h20, 'h1F, 1, 0);
    drainScoreboard("cfg_error", 50);
    checkOutput("cfg_error_code", 64'(err_code), 64'(1));
    checkOutput("cfg_error_addr_low", 64'(core_bus.mem_addr_low), 64'('h20));

    $display("[TB] job: endless replay, abort during pass 6");
    core_lat = 10;
    expectEv(EV_SWRST, 8);
    expectEv(EV_REPLAY, 10);
    for (int i = 0; i < 4; i++) begin
      expectEv(EV_GAP, 3);
      expectEv(EV_REPLAY, 10);
    end
    expectEv(EV_GAP, 3);
    expectEv(EV_REPLAY, 4);
    expectEv(EV_SWRST, 8);
    expectEv(EV_STATUS, status_val(0, 0, 0, 5));
    applyStimulus(1'b0, 'h100, 'h1FF, 0, 2);
    waitReplayPass(2, "abort_pass3");
    applyStimulus(1'b1, 'h5, 'h6, 1, 0);
    waitReplayPass(5, "abort_pass6");
    repeat (3) @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    drainScoreboard("abort_job", 300);
    checkOutput("abort_addr_low", 64'(core_bus.mem_addr_low), 64'('h100));
    checkOutput("abort_addr_high", 64'(core_bus.mem_addr_high), 64'('h1FF));
    checkOutput("abort_loops_done", 64'(loops_done), 64'(5));
    checkOutput("abort_done", 64'(done), 64'(0));

    $display("[TB] job: store never completes");
    core_lat = 0;
    expectEv(EV_SWRST, 8);
    expectEv(EV_STORE, 255);
    expectEv(EV_STATUS, status_val(0, 1, 2, 0));
    expectEv(EV_SWRST, 8);
    applyStimulus(1'b1, 'h0, 'h7FFFF, 1, 0);
    drainScoreboard("store_timeout", 600);
    checkOutput("timeout_code", 64'(err_code), 64'(2));
    core_lat = 20;

    $display("[TB] job: calibration late by 100 cycles");
    begin
      int act0;
      core_bus.init_calib_complete = 1'b0;
      expectEv(EV_SWRST, 8);
      expectEv(EV_STORE, 20);
      expectEv(EV_REPLAY, 20);
      expectEv(EV_STATUS, status_val(1, 0, 0, 1));
      act0 = act_cycles;
      applyStimulus(1'b1, 'h40, 'h40, 1, 0);
      repeat (100) @(negedge clk);
      checkOutput("calib_hold_activity", 64'(act_cycles - act0), 64'(0));
      checkOutput("calib_hold_busy", 64'(busy), 64'(1));
      core_bus.init_calib_complete = 1'b1;
      drainScoreboard("calib_job", 300);
    end

    $display("[TB] job: reset during replay, then restart");
    expectEv(EV_SWRST, 8);
    applyStimulus(1'b0, 'h10, 'h1F, 2, 0);
    waitReplayPass(0, "reset_replay");
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1 checkOutput("async_reset_outputs",
                   64'({core_bus.sw_rst, core_bus.start_store, core_bus.start_replay, busy, done,
                        error, err_code, loops_done, core_bus.mem_addr_low, core_bus.mem_addr_high}),
                   64'(0));
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    drainScoreboard("reset_mid", 10);
    expectEv(EV_SWRST, 8);
    expectEv(EV_REPLAY, 20);
    expectEv(EV_STATUS, status_val(1, 0, 0, 1));
    applyStimulus(1'b0, 'h10, 'h1F, 1, 0);
    drainScoreboard("after_reset", 200);

    $display("[TB] start and abort together while idle");
    @(negedge clk);
    cfg_mem_addr_low  = AW'('h33);
    cfg_mem_addr_high = AW'('h44);
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("start_abort_busy", 64'(busy), 64'(0));
    checkOutput("start_abort_addr_low", 64'(core_bus.mem_addr_low), 64'('h10));
    checkOutput("start_abort_done", 64'(done), 64'(1));
    drainScoreboard("start_abort", 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
